// File: rtl/fir_sched.sv
// rtl/fir_sched.sv - two-channel round-robin scheduler feeding a shared FIR engine
// Purpose: accepts samples from two channels and keeps a TAPS-deep history per
//   channel. For each granted sample it loads that channel's history into the
//   engine data memory, starts the engine, waits out its busy period and
//   presents the result.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid/in_ready[1:0]        per-channel sample handshake
//   in_data0, in_data1            channel samples
//   eng_ctrl[1:0]                 engine start (bit0) / clear (bit1) pulses
//   eng_we, eng_addr, eng_din     engine data-memory write port
//   eng_bsy, eng_dout             engine busy flag and result
//   out_valid/out_ready           result handshake
//   out_data, out_ch, out_err     result word, source channel, watchdog flag
// Macro FIR_SCHED_TIMEOUT_EN adds a watchdog that clears a hung engine.
module fir_sched #(
  parameter int DW     = 16,
  parameter int TAPS   = 8,
  parameter int TO_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              in_valid,
  input  logic [DW-1:0]           in_data0,
  input  logic [DW-1:0]           in_data1,
  output logic [1:0]              in_ready,
  output logic [1:0]              eng_ctrl,
  output logic                    eng_we,
  output logic [$clog2(TAPS)-1:0] eng_addr,
  output logic [DW-1:0]           eng_din,
  input  logic                    eng_bsy,
  input  logic [DW-1:0]           eng_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic                    out_ch,
  output logic                    out_err
);
  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  // CLEAR is only reachable when the watchdog is built in.
  typedef enum logic [2:0] {
    IDLE, GRANT, LOAD, START, WAIT_HI, WAIT_LO, RESULT, CLEAR
  } state_t;

  state_t          state_q, state_d;
  logic            last_q;
  logic            win_q;
  logic [AW-1:0]   cnt_q;
  logic [DW-1:0]   res_q;
  logic [DW-1:0]   hist_q [2][TAPS];
  logic            grant_ok;
  logic            grant_ch;
  logic            timeout;

  // Arbitration is resolved in GRANT from the requests present that cycle;
  // if both are valid the channel that did not win last time goes first.
  assign grant_ok = (state_q == GRANT) && (in_valid != 2'b00);
  assign grant_ch = (in_valid == 2'b11) ? ~last_q : in_valid[1];

`ifdef FIR_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] wd_q;
  logic          err_q;

  assign timeout = (wd_q == TW'(TO_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == START) begin
        wd_q <= '0;
      end else if (state_q == WAIT_HI || state_q == WAIT_LO) begin
        wd_q <= wd_q + 1'b1;
      end
      if (grant_ok) begin
        err_q <= 1'b0;
      end else if (state_q == CLEAR) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out_err = err_q;
`else
  logic unused_to_cyc;
  assign unused_to_cyc = (TO_CYC == 0);
  assign timeout       = 1'b0;
  assign out_err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid != 2'b00) state_d = GRANT;
      GRANT:   state_d = grant_ok ? LOAD : IDLE;
      LOAD:    if (cnt_q == LAST) state_d = START;
      START:   state_d = WAIT_HI;
      WAIT_HI: begin
        if (timeout)      state_d = CLEAR;
        else if (eng_bsy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (timeout)       state_d = CLEAR;
        else if (!eng_bsy) state_d = RESULT;
      end
      CLEAR:   state_d = RESULT;
      RESULT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 2'b00;
    eng_ctrl  = 2'b00;
    eng_we    = 1'b0;
    eng_addr  = '0;
    eng_din   = '0;
    out_valid = 1'b0;
    case (state_q)
      GRANT:  if (grant_ok) in_ready[grant_ch] = 1'b1;
      LOAD: begin
        eng_we   = 1'b1;
        eng_addr = cnt_q;
        eng_din  = hist_q[win_q][cnt_q];
      end
      START:  eng_ctrl = 2'b01;
      CLEAR:  eng_ctrl = 2'b10;
      RESULT: out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
      win_q  <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          hist_q[c][k] <= '0;
        end
      end
    end else begin
      if (grant_ok) begin
        win_q  <= grant_ch;
        last_q <= grant_ch;
        for (int k = TAPS - 1; k > 0; k--) begin
          hist_q[grant_ch][k] <= hist_q[grant_ch][k-1];
        end
        hist_q[grant_ch][0] <= grant_ch ? in_data1 : in_data0;
      end
      if (state_q == LOAD) begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
      if (state_q == WAIT_LO && !eng_bsy && !timeout) begin
        res_q <= eng_dout;
      end else if (state_q == CLEAR) begin
        res_q <= '0;
      end
    end
  end

  assign out_data = res_q;
  assign out_ch   = win_q;

endmodule

// File: doc/fir_sched.md
FIR_SCHED -- requirements
Module: fir_sched

Interface
REQ-001 Parameter DW, 16, sample/result word width.
REQ-002 Parameter TAPS, 8, filter length = per-channel history depth = engine data-memory words loaded per run.
REQ-003 Parameter TO_CYC, 255, watchdog limit in cycles (used only with FIR_SCHED_TIMEOUT_EN).
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  2  per-channel sample valid, bit n = channel n.
REQ-007 in_data0 / in_data1  input  DW each  channel 0 / channel 1 sample.
REQ-008 in_ready  output  2  per-channel accept; a sample transfers when in_valid[n] & in_ready[n] at a clock edge.
REQ-009 eng_ctrl  output  2  engine control: bit0 start pulse, bit1 clear pulse.
REQ-010 eng_we, eng_addr (clog2(TAPS)), eng_din (DW)  outputs  engine data-memory write port.
REQ-011 eng_bsy  input  1  engine busy; eng_dout  input  DW  engine result.
REQ-012 out_valid  output  1; out_ready  input  1; out_data  output  DW; out_ch  output  1; out_err  output  1 (result channel, watchdog flag).

Function
REQ-013 FSM states: IDLE, GRANT, LOAD, START, WAIT_HI, WAIT_LO, RESULT.
REQ-014 IDLE: in_ready = 0; if any in_valid is set, go to GRANT next cycle.
REQ-015 Round-robin arbitration: a single requester wins; if both are valid, the channel not in last_grant wins; last_grant updates on grant.
REQ-016 GRANT: in_ready[winner] = 1 for exactly one cycle, sample accepted, and the winner's TAPS-deep history is shifted (new sample to index 0, oldest dropped).
REQ-017 LOAD: TAPS consecutive cycles with eng_we = 1, eng_addr = k, eng_din = hist[winner][k], k = 0..TAPS-1; then START.
REQ-018 START: eng_ctrl = 2'b01 for one cycle, then WAIT_HI.
REQ-019 WAIT_HI: wait for eng_bsy = 1, then WAIT_LO. WAIT_LO: on eng_bsy = 0, register eng_dout into out_data and enter RESULT.
REQ-020 RESULT: out_valid = 1 with out_data, out_ch, and out_err held stable until out_ready = 1; then IDLE.
REQ-021 eng_ctrl = 0, eng_we = 0, and in_ready = 0 in every state and cycle not named above.
REQ-022 Minimum latency from grant to out_valid = TAPS + 4 + engine busy cycles.
REQ-023 A requester not granted keeps its sample pending; in_data is not sampled without the handshake.
REQ-024 Histories are independent per channel; a run never reads the other channel's history.

Reset
REQ-025 rst low asynchronously sets: FSM = IDLE, last_grant = 1 (channel 0 wins first), all histories = 0, and outputs in_ready, eng_ctrl, eng_we, eng_addr, eng_din, out_valid, out_data, out_ch, out_err = 0.
REQ-026 Reset asserted mid-run aborts the run immediately, with no result emitted and no clear pulse issued.

Configuration
REQ-027 Macro FIR_SCHED_TIMEOUT_EN, when defined, adds a watchdog counter that clears on entry to WAIT_HI and counts in WAIT_HI and WAIT_LO.
REQ-028 With the macro defined, if the count reaches TO_CYC: eng_ctrl = 2'b10 for one cycle, then RESULT with out_data = 0 and out_err = 1.
REQ-029 Without the macro: no watchdog logic exists, out_err is tied to 0, and WAIT states wait indefinitely.

Verification
REQ-030 Single channel 0 sample 0x0001 with engine model bsy for 10 cycles -> 8 writes at addr 0..7 with data 0x0001 then 0x0000 x7, one start pulse, and out_ch = 0.
REQ-031 Both channels valid from reset -> grant order ch0, ch1, ch0, ch1, with each ch's out_ch matching its own history.
REQ-032 Nine samples 1..9 on ch1 -> final LOAD writes 9,8,7,6,5,4,3,2 at addr 0..7.
REQ-033 out_ready held low 20 cycles -> out_valid and out_data remain stable, and no new grant occurs.
REQ-034 rst pulsed during LOAD -> all outputs 0 within the reset, and the next run of ch0 loads a zeroed history plus the new sample.
REQ-035 With FIR_SCHED_TIMEOUT_EN and eng_bsy stuck at 1 -> clear pulse after 255 cycles, then out_err = 1 and out_data = 0x0000.
